// File: rtl/fft_frame_arb.sv
`timescale 1ns/1ps
// Frame arbiter for the 64-point FFT: round-robin per-frame grant, contiguous
// 64-sample issue, and source/index tagging of the returned frames.
module fft_frame_arb #(
  parameter int MAX_INFLIGHT = 4,
  parameter int FRAME_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [9:0]  req0_re,
  input  logic [9:0]  req0_im,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [9:0]  req1_re,
  input  logic [9:0]  req1_im,
  output logic        req1_ready,
  output logic        fft_in_en,
  output logic [9:0]  fft_in_re,
  output logic [9:0]  fft_in_im,
  input  logic        fft_out_en,
  input  logic [16:0] fft_out_re,
  input  logic [16:0] fft_out_im,
  output logic        out_valid,
  output logic [16:0] out_re,
  output logic [16:0] out_im,
  output logic        out_src,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        underrun_err,
  output logic        spurious_err
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [3:0] MAXF  = 4'(MAX_INFLIGHT);
  localparam logic [2:0] LASTP = 3'(MAX_INFLIGHT - 1);
  localparam logic [3:0] GAPL  = 4'(FRAME_GAP - 1);

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d, ptr_q, ptr_d;
  logic [5:0]  scnt_q, scnt_d, ocnt_q;
  logic [3:0]  gcnt_q, gcnt_d, infl_q, infl_d;
  logic [2:0]  wptr_q, rptr_q;
  logic [7:0]  tag_q;
  logic        push, pop, stream, empty, acc;
  logic        sel_valid;
  logic [9:0]  sel_re, sel_im;
  logic        fft_in_en_q, underrun_q, spurious_q;
  logic [9:0]  fft_in_re_q, fft_in_im_q;
  logic        out_valid_q, out_src_q, out_last_q;
  logic [16:0] out_re_q, out_im_q;
  logic [5:0]  out_idx_q;

  assign stream     = (state_q == S_STREAM);
  assign req0_ready = stream && !grant_q;
  assign req1_ready = stream && grant_q;
  assign sel_valid  = grant_q ? req1_valid : req0_valid;
  assign sel_re     = grant_q ? req1_re : req0_re;
  assign sel_im     = grant_q ? req1_im : req0_im;
  assign empty      = (infl_q == 4'd0);
  assign acc        = fft_out_en && !empty;
  assign pop        = acc && (ocnt_q == 6'd63);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Registered inflight only: a pop this cycle is seen next cycle.
        if ((infl_q < MAXF) && (req0_valid || req1_valid)) begin
          grant_d = (req0_valid && req1_valid) ? ptr_q : req1_valid;
          ptr_d   = ~grant_d;
          scnt_d  = 6'd0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        scnt_d = scnt_q + 6'd1;
        if (scnt_q == 6'd63) begin
          push    = 1'b1;
          gcnt_d  = 4'd0;
          state_d = (FRAME_GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gcnt_q == GAPL) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   infl_d = infl_q + 4'd1;
      2'b01:   infl_d = infl_q - 4'd1;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
      scnt_q      <= '0;
      gcnt_q      <= '0;
      infl_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      tag_q       <= '0;
      ocnt_q      <= '0;
      fft_in_en_q <= 1'b0;
      fft_in_re_q <= '0;
      fft_in_im_q <= '0;
      underrun_q  <= 1'b0;
      spurious_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_src_q   <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      scnt_q      <= scnt_d;
      gcnt_q      <= gcnt_d;
      infl_q      <= infl_d;
      // Missing samples become zeros so the FFT still sees 64 contiguous inputs.
      fft_in_en_q <= stream;
      fft_in_re_q <= (stream && sel_valid) ? sel_re : '0;
      fft_in_im_q <= (stream && sel_valid) ? sel_im : '0;
      underrun_q  <= stream && !sel_valid;
      if (push) begin
        tag_q[wptr_q] <= grant_q;
        wptr_q        <= (wptr_q == LASTP) ? 3'd0 : wptr_q + 3'd1;
      end
      if (pop) rptr_q <= (rptr_q == LASTP) ? 3'd0 : rptr_q + 3'd1;
      out_valid_q <= acc;
      spurious_q  <= fft_out_en && empty;
      if (acc) begin
        out_re_q   <= fft_out_re;
        out_im_q   <= fft_out_im;
        out_src_q  <= tag_q[rptr_q];
        out_idx_q  <= ocnt_q;
        out_last_q <= (ocnt_q == 6'd63);
        ocnt_q     <= ocnt_q + 6'd1;
      end
    end
  end

  assign fft_in_en    = fft_in_en_q;
  assign fft_in_re    = fft_in_re_q;
  assign fft_in_im    = fft_in_im_q;
  assign underrun_err = underrun_q;
  assign spurious_err = spurious_q;
  assign out_valid    = out_valid_q;
  assign out_re       = out_re_q;
  assign out_im       = out_im_q;
  assign out_src      = out_src_q;
  assign out_idx      = out_idx_q;
  assign out_last     = out_last_q;
endmodule

// File: tb/tb_fft_frame_arb.sv
`timescale 1ns/1ps
// Directed bench for fft_frame_arb: sources are position-indexed ramps so every
// forwarded sample has a known expected value.
module tb_fft_frame_arb;
  localparam int GAP = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic v0_en = 1'b0, v1_en = 1'b0, drop_en = 1'b0;
  logic [5:0] pos0, pos1;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [9:0] req0_re, req0_im, req1_re, req1_im, fft_in_re, fft_in_im;
  logic fft_in_en, out_valid, out_src, out_last, underrun_err, spurious_err;
  logic fft_out_en = 1'b0;
  logic [16:0] fft_out_re = '0, fft_out_im = '0, out_re, out_im;
  logic [5:0] out_idx;
  int nvec = 0, nerr = 0;

  // Position within the granted frame, advanced on every ready cycle.
  always @(posedge clk) begin
    if (rst) begin
      pos0 <= '0;
      pos1 <= '0;
    end else begin
      if (req0_ready) pos0 <= pos0 + 6'd1;
      if (req1_ready) pos1 <= pos1 + 6'd1;
    end
  end

  assign req0_valid = v0_en;
  assign req0_re    = {4'd0, pos0};
  assign req0_im    = 10'd0 - {4'd0, pos0};
  assign req1_valid = v1_en && !(drop_en && pos1 >= 6'd10 && pos1 <= 6'd12);
  assign req1_re    = 10'd100 + {4'd0, pos1};
  assign req1_im    = 10'd7;

  fft_frame_arb #(.MAX_INFLIGHT(4), .FRAME_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_re(req0_re), .req0_im(req0_im), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_re(req1_re), .req1_im(req1_im), .req1_ready(req1_ready),
    .fft_in_en(fft_in_en), .fft_in_re(fft_in_re), .fft_in_im(fft_in_im),
    .fft_out_en(fft_out_en), .fft_out_re(fft_out_re), .fft_out_im(fft_out_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_src(out_src),
    .out_idx(out_idx), .out_last(out_last),
    .underrun_err(underrun_err), .spurious_err(spurious_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    nvec++;
    if ({req0_ready, req1_ready, fft_in_en, out_valid, underrun_err, spurious_err} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {req0_ready, req1_ready, fft_in_en, out_valid, underrun_err, spurious_err});
    end
    nvec++;
    if ({fft_in_re, fft_in_im, out_re, out_im, out_src, out_idx, out_last} !== '0) begin
      nerr++;
      $display("FAIL reset_data: got in_re=%0d out_idx=%0d expected 0", fft_in_re, out_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    int w;
    logic [9:0] k;
    v0_en = 1'b1;
    w = 0;
    while (!req0_ready && w < 8) begin tick; w++; end
    nvec++;
    if (w !== 1) begin nerr++; $display("FAIL single_grant_latency: got %0d expected 1", w); end
    for (int i = 0; i < 65; i++) begin
      if (i < 64) begin
        nvec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
          nerr++; $display("FAIL single_ready[%0d]: got %b expected 10", i, {req0_ready, req1_ready});
        end
      end
      if (i > 0) begin
        k = 10'(i - 1);
        nvec++;
        if ({fft_in_en, fft_in_re, fft_in_im} !== {1'b1, k, 10'd0 - k}) begin
          nerr++; $display("FAIL single_fft_in[%0d]: got en=%b re=%0d im=%0d expected en=1 re=%0d",
                           i - 1, fft_in_en, fft_in_re, fft_in_im, k);
        end
      end
      if (i == 64) v0_en = 1'b0;
      tick;
    end
    nvec++;
    if ({fft_in_en, req0_ready} !== 2'b00) begin
      nerr++; $display("FAIL single_end: got en=%b rdy=%b expected 0 0", fft_in_en, req0_ready);
    end
    for (int i = 0; i < 64; i++) begin
      fft_out_en = 1'b1;
      fft_out_re = 17'(1000 + i);
      fft_out_im = 17'(-i);
      tick;
      nvec++;
      if ({out_valid, out_src, out_idx, out_last, out_re, out_im} !==
          {1'b1, 1'b0, 6'(i), (i == 63), 17'(1000 + i), 17'(-i)}) begin
        nerr++; $display("FAIL single_out[%0d]: got v=%b src=%b idx=%0d last=%b re=%0d expected v=1 src=0 idx=%0d re=%0d",
                         i, out_valid, out_src, out_idx, out_last, out_re, i, 1000 + i);
      end
    end
    fft_out_en = 1'b0;
    tick;
    nvec++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL single_out_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_spurious;
    fft_out_en = 1'b1;
    fft_out_re = 17'd5;
    tick;
    fft_out_en = 1'b0;
    nvec++;
    if ({out_valid, spurious_err, out_idx} !== {1'b0, 1'b1, 6'd63}) begin
      nerr++; $display("FAIL spurious: got v=%b err=%b idx=%0d expected v=0 err=1 idx=63",
                       out_valid, spurious_err, out_idx);
    end
    tick;
    nvec++;
    if (spurious_err !== 1'b0) begin nerr++; $display("FAIL spurious_pulse: got %b expected 0", spurious_err); end
  endtask

  task automatic test_contention;
    int ng, c;
    int ts[4];
    logic [3:0] gs;
    logic prev;
    rst = 1'b1;
    v0_en = 1'b1;
    v1_en = 1'b1;
    tick;
    rst = 1'b0;
    ng = 0; c = 0; prev = 1'b0; gs = '0;
    while (c < 400 && ng < 4) begin
      tick;
      c++;
      if ((req0_ready || req1_ready) && !prev) begin
        gs[ng] = req1_ready;
        ts[ng] = c;
        ng++;
      end
      prev = req0_ready || req1_ready;
    end
    nvec++;
    if (ng !== 4) begin nerr++; $display("FAIL contention_grants: got %0d expected 4", ng); end
    nvec++;
    if (gs !== 4'b1010) begin nerr++; $display("FAIL contention_order: got %b expected 1010 (msb=4th)", gs); end
    for (int k = 1; k < 4; k++) begin
      nvec++;
      if (ng == 4 && ts[k] - ts[k - 1] !== 65 + GAP) begin
        nerr++; $display("FAIL contention_spacing[%0d]: got %0d expected %0d", k, ts[k] - ts[k - 1], 65 + GAP);
      end
    end
  endtask

  task automatic test_inflight_limit;
    int w, ng;
    w = 0;
    while ((req0_ready || req1_ready) && w < 80) begin tick; w++; end
    ng = 0;
    for (int i = 0; i < 150; i++) begin
      tick;
      if (req0_ready || req1_ready) ng++;
    end
    nvec++;
    if (ng !== 0) begin nerr++; $display("FAIL inflight_stall: got %0d ready cycles expected 0", ng); end
    for (int i = 0; i < 64; i++) begin
      fft_out_en = 1'b1;
      fft_out_re = 17'(i);
      tick;
      nvec++;
      if ({out_valid, out_src, out_idx, out_last, req0_ready, req1_ready} !==
          {1'b1, 1'b0, 6'(i), (i == 63), 2'b00}) begin
        nerr++; $display("FAIL inflight_ret[%0d]: got v=%b src=%b idx=%0d rdy=%b%b expected v=1 src=0 idx=%0d rdy=00",
                         i, out_valid, out_src, out_idx, req0_ready, req1_ready, i);
      end
    end
    fft_out_en = 1'b0;
    tick;
    nvec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++; $display("FAIL inflight_5th_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    repeat (64) tick;
    v0_en = 1'b0;
    v1_en = 1'b0;
  endtask

  task automatic test_drain;
    logic es;
    for (int f = 0; f < 4; f++) begin
      es = (f % 2 == 0);
      for (int i = 0; i < 64; i++) begin
        fft_out_en = 1'b1;
        fft_out_re = 17'(f * 64 + i);
        tick;
        nvec++;
        if ({out_valid, out_src, out_idx, out_last} !== {1'b1, es, 6'(i), (i == 63)}) begin
          nerr++; $display("FAIL drain[%0d][%0d]: got v=%b src=%b idx=%0d last=%b expected src=%b",
                           f, i, out_valid, out_src, out_idx, out_last, es);
        end
      end
    end
    fft_out_en = 1'b0;
    tick;
  endtask

  task automatic test_underrun;
    int w, nund;
    logic [9:0] er, ei;
    logic drop;
    v1_en = 1'b1;
    drop_en = 1'b1;
    w = 0;
    while (!req1_ready && w < 8) begin tick; w++; end
    nvec++;
    if (!req1_ready) begin nerr++; $display("FAIL underrun_grant: got ready=0 expected 1"); end
    nund = 0;
    for (int i = 0; i < 65; i++) begin
      if (i < 64) begin
        nvec++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
          nerr++; $display("FAIL underrun_ready[%0d]: got %b expected 01", i, {req0_ready, req1_ready});
        end
      end
      if (i > 0) begin
        drop = (i - 1 >= 10 && i - 1 <= 12);
        er = drop ? 10'd0 : 10'(100 + i - 1);
        ei = drop ? 10'd0 : 10'd7;
        nvec++;
        if ({fft_in_en, fft_in_re, fft_in_im, underrun_err} !== {1'b1, er, ei, drop}) begin
          nerr++; $display("FAIL underrun_sample[%0d]: got en=%b re=%0d im=%0d err=%b expected en=1 re=%0d im=%0d err=%b",
                           i - 1, fft_in_en, fft_in_re, fft_in_im, underrun_err, er, ei, drop);
        end
      end
      if (underrun_err) nund++;
      if (i == 64) begin v1_en = 1'b0; drop_en = 1'b0; end
      tick;
    end
    nvec++;
    if (fft_in_en !== 1'b0) begin nerr++; $display("FAIL underrun_end: got en=%b expected 0", fft_in_en); end
    nvec++;
    if (nund !== 3) begin nerr++; $display("FAIL underrun_count: got %0d expected 3", nund); end
  endtask

  task automatic test_reset_mid_frame;
    int w;
    logic [9:0] k;
    v0_en = 1'b1;
    w = 0;
    while (!req0_ready && w < 8) begin tick; w++; end
    repeat (30) tick;
    rst = 1'b1;
    tick;
    nvec++;
    if ({req0_ready, req1_ready, fft_in_en, fft_in_re, fft_in_im, out_valid, out_re, out_im,
         out_src, out_idx, out_last, underrun_err, spurious_err} !== '0) begin
      nerr++; $display("FAIL midrst_outputs: got rdy=%b en=%b in_re=%0d ov=%b out_re=%0d idx=%0d expected all 0",
                       req0_ready, fft_in_en, fft_in_re, out_valid, out_re, out_idx);
    end
    rst = 1'b0;
    w = 0;
    while (!req0_ready && w < 8) begin tick; w++; end
    nvec++;
    if (w !== 1) begin nerr++; $display("FAIL midrst_regrant: got %0d expected 1", w); end
    for (int i = 0; i < 65; i++) begin
      if (i > 0) begin
        k = 10'(i - 1);
        nvec++;
        if ({fft_in_en, fft_in_re, fft_in_im} !== {1'b1, k, 10'd0 - k}) begin
          nerr++; $display("FAIL midrst_fft_in[%0d]: got en=%b re=%0d expected en=1 re=%0d",
                           i - 1, fft_in_en, fft_in_re, k);
        end
      end
      if (i == 64) v0_en = 1'b0;
      tick;
    end
    nvec++;
    if (fft_in_en !== 1'b0) begin nerr++; $display("FAIL midrst_end: got en=%b expected 0", fft_in_en); end
    for (int i = 0; i < 64; i++) begin
      fft_out_en = 1'b1;
      fft_out_re = 17'(i);
      tick;
      nvec++;
      if ({out_valid, out_src, out_idx, out_last} !== {1'b1, 1'b0, 6'(i), (i == 63)}) begin
        nerr++; $display("FAIL midrst_out[%0d]: got v=%b src=%b idx=%0d expected v=1 src=0 idx=%0d",
                         i, out_valid, out_src, out_idx, i);
      end
    end
    fft_out_en = 1'b0;
    tick;
    // Only one frame may be outstanding after the reset; the next return is spurious.
    fft_out_en = 1'b1;
    tick;
    fft_out_en = 1'b0;
    nvec++;
    if ({out_valid, spurious_err} !== 2'b01) begin
      nerr++; $display("FAIL midrst_empty: got v=%b err=%b expected v=0 err=1", out_valid, spurious_err);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_spurious;
    test_contention;
    test_inflight_limit;
    test_drain;
    test_underrun;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fft_frame_arb.md
# fft_frame_arb

Frame-level arbiter and scheduler in front of the 64-point FFT pipeline. Two requesters each present complex 10-bit sample streams. The block grants one requester per frame (round-robin) and drives exactly 64 contiguous enabled samples into the FFT input. It then tags each FFT output frame with its originating source and sample index, and limits the number of frames in flight.

## Interface
- MAX_INFLIGHT, 4: maximum frames issued to the FFT but not yet fully returned; also the tag FIFO depth (1..8).
- FRAME_GAP, 2: idle cycles forced between consecutive input frames (0..15).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  source 0 has a sample / wants a frame.
- req0_re, req0_im  in  10 each  source 0 sample, two's complement.
- req0_ready  out  1  source 0 sample consumed this cycle.
- req1_valid, req1_re, req1_im, req1_ready: same as source 0, for source 1.
- fft_in_en  out  1  FFT input enable; high for exactly 64 consecutive cycles per frame.
- fft_in_re, fft_in_im  out  10 each  FFT input sample.
- fft_out_en  in  1  FFT output sample valid.
- fft_out_re, fft_out_im  in  17 each  FFT output sample.
- out_valid  out  1  tagged output sample valid.
- out_re, out_im  out  17 each  output sample.
- out_src  out  1  source id of the frame.
- out_idx  out  6  sample index within the frame (0..63).
- out_last  out  1  high with out_idx==63.
- underrun_err  out  1  one-cycle pulse: granted source not valid during a STREAM cycle.
- spurious_err  out  1  one-cycle pulse: fft_out_en with empty tag FIFO.

## Operation
- States:
  - IDLE: if inflight < MAX_INFLIGHT and any reqN_valid is high, grant a source, latch its id, and go to STREAM.
  - STREAM: 64 cycles, counted by a 6-bit sample counter.
  - GAP: FRAME_GAP cycles, then return to IDLE. FRAME_GAP==0 returns straight to IDLE.
- Round-robin arbitration:
  - A 1-bit pointer names the preferred source.
  - If both sources are valid, the preferred source wins.
  - If only one is valid, it wins.
  - The pointer is set to the non-granted source after every grant.
- STREAM behaviour:
  - Only the granted reqN_ready is high, and it is high every STREAM cycle regardless of valid.
  - The sample is forwarded when valid. When not valid, zero is forwarded and underrun_err pulses.
  - The frame is never shortened or stretched; the FFT requires contiguity.
- Frame issue: on the last STREAM cycle the source id is pushed into the tag FIFO and inflight increments.
- Return side:
  - Each fft_out_en increments a 6-bit output counter, which wraps 63 to 0.
  - The tag at the FIFO head supplies out_src.
  - On the 64th sample the tag is popped and inflight decrements.
- Simultaneous push and pop: inflight is unchanged and the FIFO stays consistent. Because FIFO depth = MAX_INFLIGHT, no overflow is possible.
- Empty tag FIFO with fft_out_en high: the sample is dropped (out_valid low), spurious_err pulses, and the output counter does not advance.
- Widths: samples pass through unmodified; there is no arithmetic on the data.
- Reset:
  - State goes to IDLE. Pointer, counters, inflight and FIFO are cleared.
  - All outputs go to 0, including ready, fft_in_*, out_*, and both err outputs.
  - Reset mid-frame abandons the frame with no tag pushed. The FFT must be reset together with this block.

## Timing
- Arbitration decision at edge t, with reqN_valid sampled in IDLE.
- reqN_ready is high for cycles t+1..t+64. Sample accepted at cycle k appears on fft_in_* / fft_in_en at k+1.
- fft_in_en is therefore high for cycles t+2..t+65.
- Next possible grant decision at t+65+FRAME_GAP.
- Back-to-back throughput is 64 samples per 65+FRAME_GAP cycles.
- inflight check uses the registered count. A pop in the same cycle as the IDLE decision is not seen until the next cycle.
- Output path: out_* are registered one cycle after fft_out_en, with 1-cycle latency. out_valid is high one cycle per accepted sample.
- Err pulses are registered and aligned with the cycle after the offending event.

## Test plan
- Single frame:
  - Stimulus: source 0 holds valid with ramp re=0..63, im=-re.
  - Required response: req0_ready high 64 cycles; fft_in_en 64 contiguous cycles carrying 0..63; req1_ready never high.
  - Feed back 64 fft_out_en: out_src=0, out_idx 0..63, out_last on idx 63.
- Contention:
  - Stimulus: both sources valid continuously from reset.
  - Required response: grants alternate 0,1,0,1; frame starts separated by exactly 65+FRAME_GAP cycles; returned frames tagged 0,1,0,1 in order.
- Underrun:
  - Stimulus: source 1 drops valid for samples 10..12 of its frame.
  - Required response: fft_in samples 10..12 are zero; underrun_err pulses 3 times; fft_in_en stays contiguous for all 64 cycles.
- Inflight limit:
  - Stimulus: MAX_INFLIGHT=4 with no fft_out_en.
  - Required response: exactly 4 frames issued, then the block stays in IDLE with valid high.
  - Then return one full frame: the 5th grant occurs the cycle after inflight drops.
- Spurious output:
  - Stimulus: fft_out_en pulse with no frame issued.
  - Required response: out_valid stays 0, spurious_err=1 for one cycle, out_idx unchanged.
- Reset mid-frame:
  - Stimulus: assert rst at sample 30.
  - Required response: next cycle all outputs are 0 and inflight is 0.
  - A new request then produces a full fresh 64-sample frame, whose returned frame starts at out_idx 0.
